sram_rr_arbiter: RTL and testbench

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

---
 rtl/sram_rr_arbiter_if.sv | 49 ++++
 rtl/sram_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_rr_arbiter_if
//   Requester-side bundle for sram_rr_arbiter: two independent request
//   channels (m0, m1), each with a request handshake and a response strobe.
//
//   Per requester mX:
//     mX_valid  requester presents a request
//     mX_ready  request accepted this cycle when valid & ready
//     mX_we     1 = write, 0 = read
//     mX_addr   10-bit word address
//     mX_wdata  32-bit write data
//     mX_rvalid one-cycle response strobe
//     mX_rdata  response data, zero while mX_rvalid = 0
//
//   Modports:
//     master  requester side (drives requests, observes responses)
//     slave   arbiter side
// ---------------------------------------------------------------------------
interface sram_rr_arbiter_if;
  logic        m0_valid;
  logic        m0_ready;
  logic        m0_we;
  logic [9:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic        m1_ready;
  logic        m1_we;
  logic [9:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  modport master (
    output m0_valid, m0_we, m0_addr, m0_wdata,
    output m1_valid, m1_we, m1_addr, m1_wdata,
    input  m0_ready, m0_rvalid, m0_rdata,
    input  m1_ready, m1_rvalid, m1_rdata
  );

  modport slave (
    input  m0_valid, m0_we, m0_addr, m0_wdata,
    input  m1_valid, m1_we, m1_addr, m1_wdata,
    output m0_ready, m0_rvalid, m0_rdata,
    output m1_ready, m1_rvalid, m1_rdata
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sram_rr_arbiter
//   Two-requester round-robin arbiter in front of a single-port 1024x32
//   SRAM (SP32B1024: active-low CEN/WEN, registered read data with one
//   cycle of latency, write-first).
//
//   After reset the block optionally zeroes the whole RAM (CLEAR state),
//   then serves one transfer per cycle (RUN state). Every accepted
//   transfer, read or write, returns a one-cycle rvalid to its requester
//   on the following cycle carrying RAM_Q.
//
//   Ports:
//     CLK, RST_N   clock, asynchronous active-low reset
//     bus          requester channels (sram_rr_arbiter_if.slave)
//     RAM_CEN      RAM chip enable, active low
//     RAM_WEN      RAM write enable, active low
//     RAM_A        RAM word address
//     RAM_D        RAM write data
//     RAM_Q        RAM read data (registered inside the RAM)
//     init_done    0 while clearing (and in reset), 1 when serving
//
//   Parameter:
//     CLEAR_ON_RESET  1 = zero all RAM words before serving, 0 = serve now
// ---------------------------------------------------------------------------
module sram_rr_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  sram_rr_arbiter_if.slave     bus,
  output logic                 RAM_CEN,
  output logic                 RAM_WEN,
  output logic [9:0]           RAM_A,
  output logic [31:0]          RAM_D,
  input  logic [31:0]          RAM_Q,
  output logic                 init_done
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  localparam logic [9:0] LAST_ADDR = 10'd1023;

  // State
  logic [0:0] state_q,     state_d;
  logic [9:0] clr_cnt_q,   clr_cnt_d;
  logic       rr_ptr_q,    rr_ptr_d;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_id_q,    tag_id_d;

  // Combinational grant and RAM command before reset gating
  logic        grant_vld;
  logic        grant_id;
  logic        sel_we;
  logic [9:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        ram_cen_c;
  logic        ram_wen_c;
  logic [9:0]  ram_a_c;
  logic [31:0] ram_d_c;

  // Mux of the granted requester's command fields.
  always_comb begin
    if (grant_id) begin
      sel_we    = bus.m1_we;
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
    end else begin
      sel_we    = bus.m0_we;
      sel_addr  = bus.m0_addr;
      sel_wdata = bus.m0_wdata;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    tag_valid_d = 1'b0;
    tag_id_d    = tag_id_q;
    grant_vld   = 1'b0;
    grant_id    = 1'b0;
    ram_cen_c   = 1'b1;
    ram_wen_c   = 1'b1;
    ram_a_c     = '0;
    ram_d_c     = '0;

    if (state_q == ST_CLEAR) begin
      // One zero-write per cycle; the counter wraps back to 0 on the
      // final address, leaving it clean for the next reset.
      ram_cen_c = 1'b0;
      ram_wen_c = 1'b0;
      ram_a_c   = clr_cnt_q;
      clr_cnt_d = clr_cnt_q + 10'd1;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end else begin
      // Contention is settled by rr_ptr; a lone requester always wins.
      if (bus.m0_valid && bus.m1_valid) begin
        grant_vld = 1'b1;
        grant_id  = rr_ptr_q;
      end else if (bus.m0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.m1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end

      if (grant_vld) begin
        // Pointer moves to the loser of this cycle, even when uncontended.
        rr_ptr_d    = ~grant_id;
        tag_valid_d = 1'b1;
        tag_id_d    = grant_id;
        ram_cen_c   = 1'b0;
        ram_wen_c   = ~sel_we;
        ram_a_c     = sel_addr;
        ram_d_c     = sel_wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_RESET;
      clr_cnt_q   <= '0;
      rr_ptr_q    <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
    end
  end

  // NOTE: the reset state is CLEAR (RAM enabled) or RUN (grants live), so
  // the RAM command, ready and init_done are gated by RST_N directly to go
  // idle the instant reset asserts, not at the next clock.
  assign RAM_CEN   = ~RST_N | ram_cen_c;
  assign RAM_WEN   = ~RST_N | ram_wen_c;
  assign RAM_A     = RST_N ? ram_a_c : '0;
  assign RAM_D     = RST_N ? ram_d_c : '0;
  assign init_done = RST_N & (state_q == ST_RUN);

  assign bus.m0_ready = RST_N & grant_vld & ~grant_id;
  assign bus.m1_ready = RST_N & grant_vld &  grant_id;

  // The tag flops reset asynchronously, so an in-flight response is
  // dropped as soon as reset asserts.
  assign bus.m0_rvalid = tag_valid_q & ~tag_id_q;
  assign bus.m1_rvalid = tag_valid_q &  tag_id_q;
  assign bus.m0_rdata  = bus.m0_rvalid ? RAM_Q : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? RAM_Q : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_rr_arbiter
//   Directed bench for sram_rr_arbiter. Instance A uses CLEAR_ON_RESET=1,
//   instance B uses CLEAR_ON_RESET=0; each has its own reset and its own
//   behavioural SP32B1024 model (registered read, write-first). Unwritten
//   RAM words read back as 0xA5A5_0000 | addr so that a cleared word is
//   distinguishable from a never-written one.
// ---------------------------------------------------------------------------
module tb_sram_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  sram_rr_arbiter_if bus_a();
  sram_rr_arbiter_if bus_b();

  logic        a_cen, a_wen, a_init;
  logic [9:0]  a_addr;
  logic [31:0] a_d, a_q;
  logic        b_cen, b_wen, b_init;
  logic [9:0]  b_addr;
  logic [31:0] b_d, b_q;

  sram_rr_arbiter #(.CLEAR_ON_RESET(1'b1)) dut_a (
    .CLK(clk), .RST_N(rst_a), .bus(bus_a),
    .RAM_CEN(a_cen), .RAM_WEN(a_wen), .RAM_A(a_addr), .RAM_D(a_d),
    .RAM_Q(a_q), .init_done(a_init)
  );

  sram_rr_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_b (
    .CLK(clk), .RST_N(rst_b), .bus(bus_b),
    .RAM_CEN(b_cen), .RAM_WEN(b_wen), .RAM_A(b_addr), .RAM_D(b_d),
    .RAM_Q(b_q), .init_done(b_init)
  );

  // RAM models
  bit [31:0] mem_a [1024];
  bit        wr_a  [1024];
  bit [31:0] mem_b [1024];
  bit        wr_b  [1024];

  function automatic logic [31:0] fill(input logic [9:0] addr);
    return 32'hA5A5_0000 | {22'd0, addr};
  endfunction

  always @(posedge clk) begin
    if (!a_cen) begin
      if (!a_wen) begin
        mem_a[a_addr] <= a_d;
        wr_a[a_addr]  <= 1'b1;
        a_q           <= a_d;
      end else begin
        a_q <= wr_a[a_addr] ? mem_a[a_addr] : fill(a_addr);
      end
    end
  end

  always @(posedge clk) begin
    if (!b_cen) begin
      if (!b_wen) begin
        mem_b[b_addr] <= b_d;
        wr_b[b_addr]  <= 1'b1;
        b_q           <= b_d;
      end else begin
        b_q <= wr_b[b_addr] ? mem_b[b_addr] : fill(b_addr);
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic v0, input logic we0, input logic [9:0] ad0,
                         input logic [31:0] d0, input logic v1, input logic we1,
                         input logic [9:0] ad1, input logic [31:0] d1);
    bus_a.m0_valid = v0; bus_a.m0_we = we0; bus_a.m0_addr = ad0; bus_a.m0_wdata = d0;
    bus_a.m1_valid = v1; bus_a.m1_we = we1; bus_a.m1_addr = ad1; bus_a.m1_wdata = d1;
  endtask

  task automatic drive_b(input logic v0, input logic we0, input logic [9:0] ad0,
                         input logic [31:0] d0);
    bus_b.m0_valid = v0; bus_b.m0_we = we0; bus_b.m0_addr = ad0; bus_b.m0_wdata = d0;
    bus_b.m1_valid = 1'b0; bus_b.m1_we = 1'b0; bus_b.m1_addr = '0; bus_b.m1_wdata = '0;
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    // Requests held high during reset: ready must still be 0.
    drive_a(1'b1, 1'b0, 10'd3, 32'd0, 1'b1, 1'b0, 10'd4, 32'd0);
    drive_b(1'b1, 1'b0, 10'd7, 32'd0);
    #2;
    check("rst_a_ram", {a_cen, a_wen, a_addr, a_d}, {1'b1, 1'b1, 10'd0, 32'd0});
    check("rst_a_hs", {bus_a.m0_ready, bus_a.m1_ready, bus_a.m0_rvalid,
                       bus_a.m1_rvalid, a_init}, 5'b00000);
    check("rst_a_rdata", {bus_a.m0_rdata, bus_a.m1_rdata}, 64'd0);
    check("rst_b_hs", {bus_b.m0_ready, b_init, b_cen}, 3'b001);
    repeat (2) @(negedge clk);

    // ---- Instance B: no clear, first cycle after release is served ----
    rst_b = 1'b1;
    #1;
    check("b_first_grant", {bus_b.m0_ready, b_init, b_cen, b_wen, b_addr},
          {1'b1, 1'b1, 1'b0, 1'b1, 10'd7});
    @(negedge clk);
    drive_b(1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    check("b_first_rsp", {bus_b.m0_rvalid, bus_b.m1_rvalid, bus_b.m0_rdata},
          {1'b1, 1'b0, 32'hA5A5_0007});
    @(negedge clk);
    #1;
    check("b_idle", {bus_b.m0_rvalid, bus_b.m0_rdata, bus_b.m0_ready, b_cen},
          {1'b0, 32'd0, 1'b0, 1'b1});

    // ---- Instance A: 1024-cycle clear with both requests pending ----
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      #1;
      check("clear", {a_cen, a_wen, a_addr, a_d, bus_a.m0_ready, bus_a.m1_ready, a_init},
            {1'b0, 1'b0, i[9:0], 32'd0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
    end

    // ---- Continuous contention right after clear: m0,m1,m0,... ----
    for (int k = 0; k < 6; k++) begin
      logic ev;
      logic [1:0] rsp_exp;
      ev = (k % 2 == 0);
      rsp_exp = (k == 0) ? 2'b00 : (ev ? 2'b01 : 2'b10);
      #1;
      check("rr_grant", {bus_a.m0_ready, bus_a.m1_ready, a_init, a_cen, a_addr},
            {ev, ~ev, 1'b1, 1'b0, ev ? 10'd3 : 10'd4});
      check("rr_rsp", {bus_a.m0_rvalid, bus_a.m1_rvalid, bus_a.m0_rdata, bus_a.m1_rdata},
            {rsp_exp, 32'd0, 32'd0});
      @(negedge clk);
    end
    drive_a(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    check("idle_bus", {a_cen, a_wen, a_addr, a_d, bus_a.m0_ready, bus_a.m1_ready},
          {1'b1, 1'b1, 10'd0, 32'd0, 1'b0, 1'b0});
    check("last_rsp", {bus_a.m0_rvalid, bus_a.m1_rvalid, bus_a.m1_rdata},
          {1'b0, 1'b1, 32'd0});

    // ---- m0 writes addr 5, m1 reads it back next cycle ----
    @(negedge clk);
    drive_a(1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    check("wr_bus", {bus_a.m0_ready, bus_a.m1_ready, a_cen, a_wen, a_addr, a_d},
          {1'b1, 1'b0, 1'b0, 1'b0, 10'd5, 32'hDEAD_BEEF});
    @(negedge clk);
    drive_a(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0);
    #1;
    check("rd_grant", {bus_a.m0_ready, bus_a.m1_ready, a_cen, a_wen, a_addr},
          {1'b0, 1'b1, 1'b0, 1'b1, 10'd5});
    check("wr_rsp", {bus_a.m0_rvalid, bus_a.m1_rvalid, bus_a.m0_rdata, bus_a.m1_rdata},
          {1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0});
    @(negedge clk);
    drive_a(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    check("rd_rsp", {bus_a.m0_rvalid, bus_a.m1_rvalid, bus_a.m0_rdata, bus_a.m1_rdata},
          {1'b0, 1'b1, 32'd0, 32'hDEAD_BEEF});

    // ---- Pointer follows uncontended m1 grants ----
    // A lone m0 transfer points rr_ptr at m1; three lone m1 transfers must
    // move it back to m0 before the first contended cycle.
    @(negedge clk);
    drive_a(1'b1, 1'b0, 10'd9, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    check("solo_m0", {bus_a.m0_ready, bus_a.m1_ready}, 2'b10);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive_a(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd10, 32'd0);
      #1;
      check("solo_m1", {bus_a.m0_ready, bus_a.m1_ready}, 2'b01);
    end
    @(negedge clk);
    drive_a(1'b1, 1'b0, 10'd11, 32'd0, 1'b1, 1'b0, 10'd12, 32'd0);
    #1;
    check("contend_first", {bus_a.m0_ready, bus_a.m1_ready, a_addr}, {2'b10, 10'd11});
    @(negedge clk);
    #1;
    check("contend_second", {bus_a.m0_ready, bus_a.m1_ready, a_addr}, {2'b01, 10'd12});

    // ---- Reset while a read response is in flight ----
    @(negedge clk);
    drive_a(1'b1, 1'b0, 10'd20, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    check("pre_rst_grant", {bus_a.m0_ready, a_cen, a_addr}, {1'b1, 1'b0, 10'd20});
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    #1;
    check("rst_async", {a_cen, a_wen, a_addr, a_d, bus_a.m0_ready, bus_a.m1_ready,
                        bus_a.m0_rvalid, bus_a.m1_rvalid, bus_a.m0_rdata, a_init},
          {1'b1, 1'b1, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("restart_clear", {a_cen, a_wen, a_addr, bus_a.m0_ready,
                              bus_a.m0_rvalid, bus_a.m1_rvalid, a_init},
            {1'b0, 1'b0, j[9:0], 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
